// File: rtl/mmio_pkg.sv
// Shared constants for the data-memory / peripheral window: window select bit,
// register selects and bit positions inside CTRL and STATUS.
package mmio_pkg;

    // Address bit that switches between RAM (0) and peripherals (1)
    localparam int WIN_BIT = 12;

    // Peripheral register select, taken from Addr[4:2]
    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,   // 0x1000
        REG_LOAD   = 3'd1,   // 0x1004
        REG_COUNT  = 3'd2,   // 0x1008
        REG_STATUS = 3'd3,   // 0x100C
        REG_LEDS   = 3'd4,   // 0x1010
        REG_SW     = 3'd5    // 0x1014
    } reg_sel_e;

    // CTRL bit indices
    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_IE     = 2;
    localparam int CTRL_W      = 3;

    // STATUS bit index
    localparam int STATUS_EXPIRED = 0;

endpackage

// File: rtl/dmem_mmio_if.sv
// CPU-side data-memory bus: address, store strobe/data and combinational load data.
interface dmem_mmio_if;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    // The core drives address and store data and consumes the load data
    modport master (
        output MemWrite,
        output Addr,
        output WriteData,
        input  ReadData
    );

    // The memory stage answers with load data
    modport slave (
        input  MemWrite,
        input  Addr,
        input  WriteData,
        output ReadData
    );
endinterface

// File: rtl/timer_unit.sv
// Down-counting timer with optional auto-reload, sticky expiry flag and
// interrupt. Software writes arrive as pre-decoded strobes plus write data.
module timer_unit
    import mmio_pkg::*;
(
    input  logic                clk,
    input  logic                reset,      // asynchronous, active low
    input  logic                wr_ctrl,
    input  logic                wr_load,
    input  logic                wr_count,
    input  logic                wr_status,
    input  logic [31:0]         wdata,
    output logic [CTRL_W-1:0]   ctrl,
    output logic [31:0]         load,
    output logic [31:0]         count,
    output logic                expired,
    output logic                irq
);

    logic [CTRL_W-1:0] ctrl_reg, ctrl_next;
    logic [31:0]       load_reg, load_next;
    logic [31:0]       count_reg, count_next;
    logic              expired_reg, expired_next;
    logic              expire;

    // Expiry is judged on the pre-write count so a same-cycle COUNT write cannot mask it
    assign expire = ctrl_reg[CTRL_EN] && (count_reg == 32'd0);

    // Next-state for all timer registers; software writes are applied last so they win,
    // except the expired flag where the hardware set has the final word
    always_comb begin
        ctrl_next    = ctrl_reg;
        load_next    = load_reg;
        count_next   = count_reg;
        expired_next = expired_reg;

        if (ctrl_reg[CTRL_EN]) begin
            if (count_reg != 32'd0) begin
                count_next = count_reg - 32'd1;
            end else if (ctrl_reg[CTRL_RELOAD]) begin
                count_next = load_reg;
            end
        end
        if (expire && !ctrl_reg[CTRL_RELOAD]) begin
            ctrl_next[CTRL_EN] = 1'b0;
        end

        if (wr_ctrl) begin
            ctrl_next = wdata[CTRL_W-1:0];
        end
        if (wr_load) begin
            load_next = wdata;
        end
        if (wr_count) begin
            count_next = wdata;
        end

        if (wr_status && wdata[STATUS_EXPIRED]) begin
            expired_next = 1'b0;
        end
        if (expire) begin
            expired_next = 1'b1;
        end
    end

    // Timer state register with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_reg    <= '0;
            load_reg    <= '0;
            count_reg   <= '0;
            expired_reg <= 1'b0;
        end else begin
            ctrl_reg    <= ctrl_next;
            load_reg    <= load_next;
            count_reg   <= count_next;
            expired_reg <= expired_next;
        end
    end

    assign ctrl    = ctrl_reg;
    assign load    = load_reg;
    assign count   = count_reg;
    assign expired = expired_reg;
    // Built only from flops, so it cannot glitch within a cycle
    assign irq     = expired_reg & ctrl_reg[CTRL_IE];

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory stage: word RAM below 0x1000, peripheral window (timer, LEDs,
// switches) with Addr[12] set. Loads are combinational, stores commit on the edge.
module dmem_mmio
    import mmio_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,      // asynchronous, active low
    dmem_mmio_if.slave  bus,
    input  logic [7:0]  sw,
    output logic [7:0]  leds,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]       mem [DEPTH];
    logic [AW-1:0]     ram_idx;
    logic              win;
    logic [2:0]        sel;
    logic              wr_periph;
    logic              wr_ram;
    logic              wr_ctrl, wr_load, wr_count, wr_status, wr_leds;

    logic [7:0]        leds_reg;
    logic [7:0]        sw_meta_reg, sw_sync_reg;

    logic [CTRL_W-1:0] t_ctrl;
    logic [31:0]       t_load, t_count;
    logic              t_expired;
    logic [31:0]       rdata;

    // Address bits outside the decoded fields are deliberately don't-care
    logic              unused_addr;
    assign unused_addr = ^bus.Addr;

    // Address decode: byte offset ignored, RAM index wraps (aliases) above DEPTH
    assign win       = bus.Addr[WIN_BIT];
    assign sel       = bus.Addr[4:2];
    assign ram_idx   = bus.Addr[AW+1:2];
    assign wr_ram    = bus.MemWrite && !win;
    assign wr_periph = bus.MemWrite && win;
    assign wr_ctrl   = wr_periph && (sel == REG_CTRL);
    assign wr_load   = wr_periph && (sel == REG_LOAD);
    assign wr_count  = wr_periph && (sel == REG_COUNT);
    assign wr_status = wr_periph && (sel == REG_STATUS);
    assign wr_leds   = wr_periph && (sel == REG_LEDS);

    // RAM store port; contents are intentionally left uninitialised by reset
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            mem[ram_idx] <= bus.WriteData;
        end
    end

    // LED output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds_reg <= '0;
        end else if (wr_leds) begin
            leds_reg <= bus.WriteData[7:0];
        end
    end

    // Two-flop synchroniser for the asynchronous switch inputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
        end else begin
            sw_meta_reg <= sw;
            sw_sync_reg <= sw_meta_reg;
        end
    end

    timer_unit u_timer (
        .clk       (clk),
        .reset     (reset),
        .wr_ctrl   (wr_ctrl),
        .wr_load   (wr_load),
        .wr_count  (wr_count),
        .wr_status (wr_status),
        .wdata     (bus.WriteData),
        .ctrl      (t_ctrl),
        .load      (t_load),
        .count     (t_count),
        .expired   (t_expired),
        .irq       (irq)
    );

    // Combinational load mux; unused selects and unused bits read as zero
    always_comb begin
        rdata = 32'd0;
        if (!win) begin
            rdata = mem[ram_idx];
        end else begin
            case (sel)
                REG_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, t_ctrl};
                REG_LOAD:   rdata = t_load;
                REG_COUNT:  rdata = t_count;
                REG_STATUS: rdata = {31'd0, t_expired};
                REG_LEDS:   rdata = {24'd0, leds_reg};
                REG_SW:     rdata = {24'd0, sw_sync_reg};
                default:    rdata = 32'd0;
            endcase
        end
    end

    assign bus.ReadData = rdata;
    assign leds         = leds_reg;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM, one-shot/reload timer, collisions,
// LEDs/switches and asynchronous reset, with hand-computed expectations.
module tb_dmem_mmio;

    localparam logic [31:0] A_CTRL   = 32'h0000_1000;
    localparam logic [31:0] A_LOAD   = 32'h0000_1004;
    localparam logic [31:0] A_COUNT  = 32'h0000_1008;
    localparam logic [31:0] A_STATUS = 32'h0000_100C;
    localparam logic [31:0] A_LEDS   = 32'h0000_1010;
    localparam logic [31:0] A_SW     = 32'h0000_1014;
    localparam logic [31:0] A_SEL6   = 32'h0000_1018;
    localparam logic [31:0] A_SEL7   = 32'h0000_101C;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] sw    = 8'h00;
    logic [7:0] leds;
    logic       irq;

    int errors = 0;
    int checks = 0;

    dmem_mmio_if bus ();

    dmem_mmio #(.DEPTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .sw    (sw),
        .leds  (leds),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Store: set up at the falling edge, commit at the next rising edge
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.Addr      = a;
        bus.WriteData = d;
        bus.MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        bus.MemWrite  = 1'b0;
        $display("wr  addr=%08h data=%08h", a, d);
    endtask

    // Combinational load plus check
    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.Addr = a;
        #1;
        $display("rd  addr=%08h data=%08h", a, bus.ReadData);
        check_eq(tag, bus.ReadData, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.MemWrite  = 1'b0;
        bus.Addr      = 32'd0;
        bus.WriteData = 32'd0;

        // Reset state
        #12;
        check_eq("rst_leds", {24'd0, leds}, 32'd0);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        rd_chk("rst_ctrl", A_CTRL, 32'd0);
        rd_chk("rst_count", A_COUNT, 32'd0);
        rd_chk("rst_status", A_STATUS, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // RAM: same-cycle read sees the old word, next cycle the new one
        wr(32'h4, 32'h1111_1111);
        @(negedge clk);
        bus.Addr      = 32'h4;
        bus.WriteData = 32'hDEAD_BEEF;
        bus.MemWrite  = 1'b1;
        #1;
        check_eq("ram_same_cycle_old", bus.ReadData, 32'h1111_1111);
        @(posedge clk);
        #1;
        bus.MemWrite = 1'b0;
        $display("wr  addr=%08h data=%08h", 32'h4, 32'hDEAD_BEEF);
        rd_chk("ram_load", 32'h4, 32'hDEAD_BEEF);
        rd_chk("ram_alias", 32'h4 + 32'd256, 32'hDEAD_BEEF);
        rd_chk("ram_byte_off", 32'h7, 32'hDEAD_BEEF);
        wr(32'h8, 32'h1234_5678);
        rd_chk("ram_other_word", 32'h8, 32'h1234_5678);
        rd_chk("ram_keep", 32'h4, 32'hDEAD_BEEF);

        // One-shot: COUNT=3, enable with ie -> expiry on the 4th edge
        wr(A_COUNT, 32'd3);
        wr(A_CTRL, 32'h5);
        tick(3);
        check_eq("oneshot_irq_e3", {31'd0, irq}, 32'd0);
        rd_chk("oneshot_count_e3", A_COUNT, 32'd0);
        tick(1);
        check_eq("oneshot_irq_e4", {31'd0, irq}, 32'd1);
        rd_chk("oneshot_status", A_STATUS, 32'd1);
        rd_chk("oneshot_ctrl", A_CTRL, 32'h4);
        rd_chk("oneshot_count_hold", A_COUNT, 32'd0);
        wr(A_STATUS, 32'd0);
        rd_chk("status_w0_noeffect", A_STATUS, 32'd1);
        wr(A_STATUS, 32'd1);
        check_eq("oneshot_irq_clr", {31'd0, irq}, 32'd0);
        rd_chk("oneshot_status_clr", A_STATUS, 32'd0);

        // Auto-reload: LOAD=2, COUNT=2, en+reload -> expiry every 3 cycles
        wr(A_LOAD, 32'd2);
        wr(A_COUNT, 32'd2);
        wr(A_CTRL, 32'h3);                       // edge E0
        tick(2);                                 // E2
        rd_chk("reload_count_e2", A_COUNT, 32'd0);
        tick(1);                                 // E3: expiry
        rd_chk("reload_status_e3", A_STATUS, 32'd1);
        check_eq("reload_irq_masked", {31'd0, irq}, 32'd0);
        rd_chk("reload_count_e3", A_COUNT, 32'd2);
        wr(A_STATUS, 32'd1);                     // E4
        rd_chk("reload_status_e4", A_STATUS, 32'd0);
        rd_chk("reload_count_e4", A_COUNT, 32'd1);
        tick(1);                                 // E5
        rd_chk("reload_status_e5", A_STATUS, 32'd0);
        tick(1);                                 // E6: expiry
        rd_chk("reload_status_e6", A_STATUS, 32'd1);
        rd_chk("reload_count_e6", A_COUNT, 32'd2);

        // Collisions
        tick(2);                                 // E8
        wr(A_STATUS, 32'd1);                     // E9: expiry beats the clear
        rd_chk("coll_status_set_wins", A_STATUS, 32'd1);
        rd_chk("coll_count_reload", A_COUNT, 32'd2);
        wr(A_COUNT, 32'd100);                    // E10: write beats decrement
        rd_chk("coll_count_write", A_COUNT, 32'd100);
        tick(1);
        rd_chk("coll_count_dec", A_COUNT, 32'd99);
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'd1);
        rd_chk("stop_status", A_STATUS, 32'd0);

        // One-shot expiry while software rewrites CTRL: the write wins
        wr(A_COUNT, 32'd0);
        wr(A_CTRL, 32'h1);                       // enable, expiry at next edge
        wr(A_CTRL, 32'h5);                       // that edge: expiry + CTRL write
        rd_chk("coll_ctrl_write_wins", A_CTRL, 32'h5);
        check_eq("coll_ctrl_irq", {31'd0, irq}, 32'd1);
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'd1);

        // LEDs and switches
        wr(A_LEDS, 32'hFFFF_FF5A);
        check_eq("leds_out", {24'd0, leds}, 32'h5A);
        rd_chk("leds_read", A_LEDS, 32'h0000_005A);
        sw = 8'hC3;
        tick(1);
        rd_chk("sw_1edge", A_SW, 32'd0);
        tick(1);
        rd_chk("sw_2edge", A_SW, 32'h0000_00C3);
        wr(A_SW, 32'h0);
        rd_chk("sw_ro", A_SW, 32'h0000_00C3);
        wr(A_SEL6, 32'hFFFF_FFFF);
        rd_chk("sel6_zero", A_SEL6, 32'd0);
        rd_chk("sel7_zero", A_SEL7, 32'd0);
        rd_chk("leds_after_sel6", A_LEDS, 32'h0000_005A);

        // Asynchronous reset mid-count with irq and leds active
        wr(A_LOAD, 32'd50);
        wr(A_COUNT, 32'd0);
        wr(A_CTRL, 32'h7);                       // E0
        tick(3);                                 // E1 reload 50, E3 -> 48
        check_eq("pre_rst_irq", {31'd0, irq}, 32'd1);
        rd_chk("pre_rst_count", A_COUNT, 32'd48);
        reset = 1'b0;
        #1;
        check_eq("arst_leds", {24'd0, leds}, 32'd0);
        check_eq("arst_irq", {31'd0, irq}, 32'd0);
        rd_chk("arst_count", A_COUNT, 32'd0);
        rd_chk("arst_ram_kept", 32'h4, 32'hDEAD_BEEF);
        tick(2);
        @(negedge clk);
        reset = 1'b1;
        tick(4);
        rd_chk("post_rst_ctrl", A_CTRL, 32'd0);
        rd_chk("post_rst_count", A_COUNT, 32'd0);
        wr(A_COUNT, 32'd5);
        tick(3);
        rd_chk("post_rst_idle", A_COUNT, 32'd5);
        check_eq("post_rst_irq", {31'd0, irq}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
